// File: rtl/apb_master_arbiter_if.sv
// Requester-side and APB-side signal bundle for the two-requester APB master.
// The master modport is the arbiter's view; the slave modport is the opposite side
// (requesters plus APB slaves), used by whatever surrounds the arbiter.
interface apb_master_arbiter_if #(
  parameter int NUM_SLV = 4
);
  logic                   m0_req;
  logic                   m0_write;
  logic [31:0]            m0_addr;
  logic [31:0]            m0_wdata;
  logic [31:0]            m0_rdata;
  logic                   m0_done;
  logic                   m0_err;

  logic                   m1_req;
  logic                   m1_write;
  logic [31:0]            m1_addr;
  logic [31:0]            m1_wdata;
  logic [31:0]            m1_rdata;
  logic                   m1_done;
  logic                   m1_err;

  logic [31:0]            PADDR;
  logic [31:0]            PWDATA;
  logic                   PWRITE;
  logic                   PENABLE;
  logic [NUM_SLV-1:0]     PSEL;
  logic [32*NUM_SLV-1:0]  PRDATA;
  logic [NUM_SLV-1:0]     PREADY;

  modport master (
    input  m0_req, m0_write, m0_addr, m0_wdata,
    output m0_rdata, m0_done, m0_err,
    input  m1_req, m1_write, m1_addr, m1_wdata,
    output m1_rdata, m1_done, m1_err,
    output PADDR, PWDATA, PWRITE, PENABLE, PSEL,
    input  PRDATA, PREADY
  );

  modport slave (
    output m0_req, m0_write, m0_addr, m0_wdata,
    input  m0_rdata, m0_done, m0_err,
    output m1_req, m1_write, m1_addr, m1_wdata,
    input  m1_rdata, m1_done, m1_err,
    input  PADDR, PWDATA, PWRITE, PENABLE, PSEL,
    output PRDATA, PREADY
  );
endinterface

// File: rtl/apb_master_arbiter.sv
// Two-requester APB master: round-robin arbitration, address decode to one PSEL
// per slave, SETUP/ACCESS sequencing with a bounded wait on PREADY.
// Every output comes straight from a flop; the output process computes the
// value those flops take on the next edge from the next state.
module apb_master_arbiter #(
  parameter int NUM_SLV = 4,
  parameter int TIMEOUT = 16
) (
  input  logic PCLK,
  input  logic PRESET,
  apb_master_arbiter_if.master bus
);
  localparam int SW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [4:0]    NSLV  = 5'(NUM_SLV);
  localparam logic [CW-1:0] WLAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
  state_t state, nxt;

  logic [1:0]       req, wr;
  logic [1:0][31:0] addr, wdata;
  logic [31:0]      prd [NUM_SLV];

  assign req   = {bus.m1_req, bus.m0_req};
  assign wr    = {bus.m1_write, bus.m0_write};
  assign addr  = {bus.m1_addr, bus.m0_addr};
  assign wdata = {bus.m1_wdata, bus.m0_wdata};

  for (genvar k = 0; k < NUM_SLV; k++) begin : g_prd
    assign prd[k] = bus.PRDATA[32*k +: 32];
  end

  logic               last_grant, own_q, own_d, gnt, any_req, hit, rdy, fail;
  logic [SW-1:0]      sel_q, sel_d, dec_sel;
  logic [CW-1:0]      wcnt;
  logic [NUM_SLV-1:0] psel_q, psel_d;
  logic               pen_q, pen_d, pwrite_q;
  logic [31:0]        paddr_q, pwdata_q;
  logic [1:0]         done_q, done_d, err_q, err_d;
  logic [1:0][31:0]   rdata_q;

  // Arbitration (ties go to whoever was not granted last) and address decode
  always_comb begin
    any_req = |req;
    gnt     = (&req) ? ~last_grant : req[1];
    hit     = (addr[gnt][31:16] == 16'h1000) && ({1'b0, addr[gnt][15:12]} < NSLV);
    dec_sel = addr[gnt][12 +: SW];
    rdy     = bus.PREADY[sel_q];
  end

  // State register
  always_ff @(posedge PCLK) begin
    if (PRESET) state <= IDLE;
    else        state <= nxt;
  end

  // Next state: a decode miss skips the bus entirely; ACCESS ends on PREADY or timeout
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (any_req) nxt = hit ? SETUP : DONE;
      SETUP:   nxt = ACCESS;
      ACCESS:  if (rdy || (wcnt == WLAST)) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Output values for the next cycle, derived from the state being entered
  always_comb begin
    own_d  = (state == IDLE) ? gnt : own_q;
    sel_d  = (state == IDLE) ? dec_sel : sel_q;
    fail   = (state == IDLE) ? 1'b1 : ~rdy;
    psel_d = '0;
    pen_d  = 1'b0;
    done_d = '0;
    err_d  = '0;
    case (nxt)
      SETUP:   psel_d[sel_d] = 1'b1;
      ACCESS: begin
        psel_d[sel_d] = 1'b1;
        pen_d         = 1'b1;
      end
      DONE: begin
        done_d[own_d] = 1'b1;
        err_d[own_d]  = fail;
      end
      default: ;
    endcase
  end

  // Output flops, latched transfer attributes and the ACCESS wait counter
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      psel_q     <= '0;
      pen_q      <= 1'b0;
      done_q     <= '0;
      err_q      <= '0;
      rdata_q    <= '0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      pwrite_q   <= 1'b0;
      last_grant <= 1'b1;
      own_q      <= 1'b0;
      sel_q      <= '0;
      wcnt       <= '0;
    end else begin
      psel_q <= psel_d;
      pen_q  <= pen_d;
      done_q <= done_d;
      err_q  <= err_d;
      if (state == IDLE && any_req) begin
        last_grant <= gnt;
        own_q      <= gnt;
        sel_q      <= dec_sel;
        paddr_q    <= addr[gnt];
        pwdata_q   <= wdata[gnt];
        pwrite_q   <= wr[gnt];
      end
      wcnt <= (state == ACCESS) ? wcnt + 1'b1 : '0;
      // Errors clear the read data; successful writes leave it untouched
      if (nxt == DONE) begin
        if (fail)           rdata_q[own_d] <= '0;
        else if (!pwrite_q) rdata_q[own_d] <= prd[sel_q];
      end
    end
  end

  assign bus.PSEL     = psel_q;
  assign bus.PENABLE  = pen_q;
  assign bus.PADDR    = paddr_q;
  assign bus.PWDATA   = pwdata_q;
  assign bus.PWRITE   = pwrite_q;
  assign bus.m0_done  = done_q[0];
  assign bus.m1_done  = done_q[1];
  assign bus.m0_err   = err_q[0];
  assign bus.m1_err   = err_q[1];
  assign bus.m0_rdata = rdata_q[0];
  assign bus.m1_rdata = rdata_q[1];
endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: APB slave memories with programmable wait states,
// a transaction-level reference model feeding an expected-completion queue, and a
// monitor that checks bus phases and completions against that queue.
module tb_apb_master_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  apb_master_arbiter_if #(.NUM_SLV(4)) bus();
  apb_master_arbiter #(.NUM_SLV(4), .TIMEOUT(16)) dut (.PCLK(clk), .PRESET(rst), .bus(bus.master));

  typedef struct {
    bit        id;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit        wr;
    bit [3:0]  psel;
    bit        err;
    bit [31:0] rdata;
    int        cyc;
  } exp_t;

  exp_t      exp_q[$];
  int        n_cmp = 0;
  int        n_bad = 0;
  int        cyc   = 0;

  // slave environment
  bit [31:0] smem [4][1024];
  int        acnt [4];
  int        waits [4];
  bit        stuck [4];

  // reference model state
  bit [31:0] mdl_mem [bit [11:0]];
  bit [31:0] last_rd [2];
  bit        lg;

  // current transfer of each requester
  bit        tx_wr [2];
  bit [31:0] tx_addr [2];
  bit [31:0] tx_wd [2];

  always @(posedge clk) cyc <= cyc + 1;

  // Slaves: PREADY comes waits+1 cycles after PENABLE rises; stuck slaves never answer
  for (genvar k = 0; k < 4; k++) begin : g_slv
    assign bus.PRDATA[32*k +: 32] = smem[k][bus.PADDR[11:2]];
    assign bus.PREADY[k] = bus.PSEL[k] && bus.PENABLE && !stuck[k] && (acnt[k] == waits[k] + 1);
  end

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      acnt[k] <= (bus.PSEL[k] && bus.PENABLE) ? acnt[k] + 1 : 0;
      if (bus.PSEL[k] && bus.PENABLE && bus.PREADY[k] && bus.PWRITE)
        smem[k][bus.PADDR[11:2]] <= bus.PWDATA;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", nm, act, req);
    end
  endtask

  // Expected outcome of one transfer, from the address map and slave behaviour.
  // t is the cycle at which the request is first seen in an idle arbiter; the
  // return value is that cycle for whatever is granted next.
  function automatic int model_one(input bit id, input int t);
    exp_t      e;
    int        slv, acc;
    bit [11:0] key;
    e.id    = id;
    e.addr  = tx_addr[id];
    e.wdata = tx_wd[id];
    e.wr    = tx_wr[id];
    slv     = int'(tx_addr[id][15:12]);
    if (tx_addr[id][31:16] != 16'h1000 || slv >= 4) begin
      e.psel = 4'b0; e.err = 1'b1; e.rdata = 32'h0; e.cyc = t + 1;
    end else begin
      e.psel = 4'(1 << slv);
      acc    = stuck[slv] ? 17 : waits[slv] + 2;   // ACCESS cycles the slave needs
      if (acc > 16) begin
        e.err = 1'b1; e.rdata = 32'h0; e.cyc = t + 18;
      end else begin
        e.err = 1'b0;
        e.cyc = t + 2 + acc;
        key   = {2'(slv), tx_addr[id][11:2]};
        if (tx_wr[id]) begin
          mdl_mem[key] = tx_wd[id];
          e.rdata      = last_rd[id];
        end else begin
          e.rdata = mdl_mem.exists(key) ? mdl_mem[key] : 32'h0;
        end
      end
    end
    last_rd[id] = e.rdata;
    lg          = id;
    exp_q.push_back(e);
    return e.cyc + 1;
  endfunction

  function automatic void model_round(input bit [1:0] who, input int t0);
    int t = t0;
    if (who == 2'b11) begin
      bit first = ~lg;
      t = model_one(first, t);
      t = model_one(~first, t);
    end else begin
      t = model_one(who[1], t);
    end
  endfunction

  function automatic void model_reset();
    lg = 1'b1;
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
  endfunction

  task automatic set_tx(input bit id, input bit w, input bit [31:0] a, input bit [31:0] d);
    tx_wr[id] = w; tx_addr[id] = a; tx_wd[id] = d;
  endtask

  task automatic drive_req(input bit [1:0] who);
    bus.m0_write = tx_wr[0]; bus.m0_addr = tx_addr[0]; bus.m0_wdata = tx_wd[0];
    bus.m1_write = tx_wr[1]; bus.m1_addr = tx_addr[1]; bus.m1_wdata = tx_wd[1];
    bus.m0_req = who[0];
    bus.m1_req = who[1];
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  // One round: chosen requesters raise req together at a negedge of an idle
  // cycle, each drops req when it sees its done; ends in the following idle cycle.
  task automatic run_round(input bit [1:0] who);
    bit [1:0] pend = who;
    int       budget = 0;
    model_round(who, cyc);
    drive_req(who);
    while (pend != 2'b00 && budget < 100) begin
      @(negedge clk);
      budget++;
      if (pend[0] && bus.m0_done) begin bus.m0_req = 1'b0; pend[0] = 1'b0; end
      if (pend[1] && bus.m1_done) begin bus.m1_req = 1'b0; pend[1] = 1'b0; end
    end
    if (pend != 2'b00) begin
      chk("round_timeout", 32'(pend), 32'h0);
      bus.m0_req = 1'b0;
      bus.m1_req = 1'b0;
      exp_q.delete();
      do_reset();
    end
    @(negedge clk);
  endtask

  function automatic bit [31:0] rand_addr();
    int        r = $urandom_range(0, 9);
    bit [31:0] a;
    if (r < 8)       a = {16'h1000, 4'(r % 4), 12'h0} | {22'h0, 8'($urandom_range(0, 7)), 2'b00};
    else if (r == 8) a = 32'h1000_4000 | {22'h0, 8'($urandom_range(0, 7)), 2'b00};
    else begin
      a = $urandom;
      if (a[31:16] == 16'h1000) a[31:16] = 16'h1001;
    end
    return a;
  endfunction

  // Monitor: bus phase checks while a slave is selected, completion checks on done
  logic [3:0] prev_psel;
  always @(negedge clk) begin
    exp_t e;
    bit   id;
    if (rst) begin
      prev_psel <= 4'h0;
    end else begin
      if (bus.PSEL != 4'h0) begin
        if (exp_q.size() == 0) chk("psel_unexpected", 32'(bus.PSEL), 32'h0);
        else begin
          chk("psel",    32'(bus.PSEL),   32'(exp_q[0].psel));
          chk("paddr",   bus.PADDR,       exp_q[0].addr);
          chk("pwdata",  bus.PWDATA,      exp_q[0].wdata);
          chk("pwrite",  32'(bus.PWRITE), 32'(exp_q[0].wr));
          chk("penable", 32'(bus.PENABLE), 32'(prev_psel != 4'h0));
        end
      end
      if (bus.m0_done || bus.m1_done) begin
        if (bus.m0_done && bus.m1_done)
          chk("done_both", 32'({bus.m1_done, bus.m0_done}), 32'h1);
        else if (exp_q.size() == 0)
          chk("done_unexpected", 32'({bus.m1_done, bus.m0_done}), 32'h0);
        else begin
          e  = exp_q.pop_front();
          id = bus.m1_done;
          chk("done_id",    32'(id), 32'(e.id));
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
          chk("err",   32'(id ? bus.m1_err : bus.m0_err), 32'(e.err));
          chk("rdata", id ? bus.m1_rdata : bus.m0_rdata, e.rdata);
        end
      end
      prev_psel <= bus.PSEL;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t ab;
    bus.m0_req = 1'b0; bus.m0_write = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 1'b0; bus.m1_write = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
    for (int k = 0; k < 4; k++) begin waits[k] = 0; stuck[k] = 1'b0; end
    model_reset();
    repeat (3) @(negedge clk);

    // reset values
    chk("rst_psel",    32'(bus.PSEL), 32'h0);
    chk("rst_penable", 32'(bus.PENABLE), 32'h0);
    chk("rst_pwrite",  32'(bus.PWRITE), 32'h0);
    chk("rst_paddr",   bus.PADDR, 32'h0);
    chk("rst_pwdata",  bus.PWDATA, 32'h0);
    chk("rst_done",    32'({bus.m1_done, bus.m0_done}), 32'h0);
    chk("rst_err",     32'({bus.m1_err, bus.m0_err}), 32'h0);
    chk("rst_rdata0",  bus.m0_rdata, 32'h0);
    chk("rst_rdata1",  bus.m1_rdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // write then read back through slave 0
    set_tx(0, 1'b1, 32'h1000_0004, 32'hDEAD_BEEF); run_round(2'b01);
    set_tx(0, 1'b0, 32'h1000_0004, 32'h0);         run_round(2'b01);

    // simultaneous requests alternate
    for (int i = 0; i < 4; i++) begin
      set_tx(0, 1'($urandom), {16'h1000, 4'(i), 12'h0} | 32'h10, $urandom);
      set_tx(1, 1'($urandom), 32'h1000_0004, $urandom);
      run_round(2'b11);
    end

    // decode misses: foreign region and first slave index past the map
    set_tx(1, 1'b0, 32'h2000_0000, 32'h0); run_round(2'b10);
    set_tx(0, 1'b1, 32'h1000_4000, 32'h5); run_round(2'b01);

    // slave 2 never ready -> timeout
    stuck[2] = 1'b1;
    set_tx(0, 1'b0, 32'h1000_2010, 32'h0); run_round(2'b01);
    stuck[2] = 1'b0;

    // slave 1 with three wait states, then read back
    waits[1] = 3;
    set_tx(1, 1'b1, 32'h1000_1008, 32'h1234_5678); run_round(2'b10);
    set_tx(0, 1'b0, 32'h1000_1008, 32'h0);         run_round(2'b01);
    waits[1] = 0;

    // ready on the last allowed ACCESS cycle succeeds, one later times out
    waits[3] = 14; set_tx(0, 1'b1, 32'h1000_3000, 32'hA5A5_0001); run_round(2'b01);
    waits[3] = 15; set_tx(1, 1'b0, 32'h1000_3000, 32'h0);         run_round(2'b10);
    waits[3] = 14; set_tx(1, 1'b0, 32'h1000_3000, 32'h0);         run_round(2'b10);
    waits[3] = 0;

    // reset during ACCESS: bus drops at once, no done, m0 wins the next tie
    set_tx(0, 1'b0, 32'h1000_0000, 32'h0); run_round(2'b01);   // leaves last grant on m0
    waits[1] = 3;
    set_tx(0, 1'b1, 32'h1000_1010, 32'hCAFE_F00D);
    ab = '{id: 1'b0, addr: 32'h1000_1010, wdata: 32'hCAFE_F00D, wr: 1'b1,
           psel: 4'b0010, err: 1'b0, rdata: 32'h0, cyc: -1};
    exp_q.push_back(ab);
    drive_req(2'b01);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_psel",    32'(bus.PSEL), 32'h0);
    chk("abort_penable", 32'(bus.PENABLE), 32'h0);
    chk("abort_done",    32'(bus.m0_done), 32'h0);
    bus.m0_req = 1'b0;
    exp_q.delete();
    rst = 1'b0;
    model_reset();
    waits[1] = 0;
    @(negedge clk);
    chk("abort_no_done", 32'({bus.m1_done, bus.m0_done}), 32'h0);
    set_tx(0, 1'b0, 32'h1000_0004, 32'h0);
    set_tx(1, 1'b0, 32'h1000_1010, 32'h0);
    run_round(2'b11);

    // randomized traffic
    for (int i = 0; i < 150; i++) begin
      bit [1:0] who = 2'($urandom_range(1, 3));
      for (int k = 0; k < 4; k++) waits[k] = $urandom_range(0, 3);
      if ($urandom_range(0, 19) == 0) stuck[$urandom_range(0, 3)] = 1'b1;
      set_tx(0, 1'($urandom), rand_addr(), $urandom);
      set_tx(1, 1'($urandom), rand_addr(), $urandom);
      run_round(who);
      for (int k = 0; k < 4; k++) stuck[k] = 1'b0;
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
